data_mem_controller: RTL and testbench
======================================

# data_mem_controller

Multi-cycle data-memory access sequencer between the core's decode/execute stage and the data-memory bus. Takes the decoded memory request (request, write, funct3) with the ALU-computed address and store data, and runs a valid/ready bus transaction with byte enables. It returns sign- or zero-extended load data and stalls the core until the access completes. It also flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 255: cycles spent in ADDR+RDATA before an access is abandoned (8-bit counter, 1..255).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_memReq  in  1  decoded memory request; held stable by the core while o_stall=1.
- i_memWrite  in  1  1=store, 0=load.
- i_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2]=1 zero-extend load.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  core must hold its current instruction.
- o_rdata  out  32  extended load data, valid when o_rdataValid=1.
- o_rdataValid  out  1  one-cycle pulse on load completion.
- o_misaligned  out  1  one-cycle pulse, access rejected.
- o_busErr  out  1  one-cycle pulse, access timed out.
- o_busValid  out  1  bus request valid.
- i_busReady  in  1  bus accepts request.
- o_busWrite  out  1  bus write.
- o_busAddr  out  32  word address ({addr[31:2],2'b00}).
- o_busWdata  out  32  lane-replicated store data.
- o_busBe  out  4  byte enables (0000 on reads).
- i_busRvalid  in  1  read data valid.
- i_busRdata  in  32  read data word.

## Operation
- States: IDLE, ADDR, RDATA, DONE. Reset state IDLE.
- IDLE, i_memReq=0: no action, o_stall=0.
- IDLE, i_memReq=1, misaligned: o_misaligned=1 (combinational, same cycle), o_stall=0, stay IDLE, no bus activity. Misaligned means size=11, half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, i_memReq=1, aligned: o_stall=1 (combinational). Latch write, size, unsigned, addr and wdata. Clear the timeout counter and go to ADDR.
- ADDR: o_busValid=1, o_stall=1.
  - i_busReady=1 and store: go to DONE.
  - i_busReady=1 and load: go to RDATA.
- RDATA: o_stall=1, o_busValid=0. On i_busRvalid=1, register the extended data into o_rdata and go to DONE.
- DONE: o_stall=0. For a load, o_rdataValid=1. Always go to IDLE. The core advances at the end of this cycle.
- Timeout: the counter increments each cycle in ADDR/RDATA. At TIMEOUT cycles without completion, go to DONE with o_busErr=1, o_rdataValid=0, o_busValid dropped.
- Byte enables and store data:
  - byte: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - word: be=1111.
- Load extract:
  - byte lane = addr[1:0].
  - half lane = addr[1].
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- i_busRvalid outside RDATA is ignored.

## Timing
- Reset (async, any state): state=IDLE, counter=0. o_busValid, o_busWrite, o_rdataValid, o_busErr all 0. o_busAddr, o_busWdata, o_rdata 0; o_busBe 0000. Any in-flight bus response is discarded.
- Bus outputs are driven from latched registers. They are stable for the whole ADDR state and independent of i_addr/i_wdata after acceptance.
- Zero-wait store: IDLE(stall) → ADDR(ready) → DONE. 2 stall cycles, completes in the 3rd cycle.
- Zero-wait load, rvalid the cycle after ready: IDLE → ADDR → RDATA → DONE. 3 stall cycles; o_rdataValid in the 4th cycle.
- Back-to-back accesses: minimum 1 idle-accept cycle per access (DONE→IDLE). No request is lost because the core advances only in DONE.
- The counter saturates at TIMEOUT. o_busErr and o_rdataValid are never both 1.

## Test plan
- Store byte: addr=0x1003, wdata=0x000000A5, funct3=000 → o_busAddr=0x1000, o_busBe=1000, o_busWdata=0xA5A5A5A5, ready immediate → exactly 2 stall cycles, then DONE.
- Load half, signed vs. unsigned: addr=0x2002, rdata=0x8001_1234.
  - funct3=001 → o_rdata=0xFFFF8001.
  - funct3=101 → 0x00008001.
  - o_rdataValid pulses once in both cases.
- Misaligned: lw addr=0x3001 → o_misaligned=1 same cycle, o_stall=0, o_busValid never asserts. lh addr=0x3001 → same result.
- Wait states: ready delayed 3 cycles, rvalid delayed 2 cycles → o_busValid held 4 cycles with stable addr/be, stall until DONE, correct load data (lbu addr=0x4001, rdata=0x11223344 → 0x00000033).
- Timeout: TIMEOUT=8, ready never asserts → o_busErr pulses after 8 ADDR cycles, no o_rdataValid, state returns to IDLE.
- Reset mid-op: assert i_rst_n=0 in RDATA → all outputs 0 immediately. A later i_busRvalid is ignored, and a fresh load completes normally.

Source files
------------

// File: rtl/data_mem_controller.sv
// data_mem_controller
// Multi-cycle data-memory access sequencer. Accepts a decoded load/store
// from the core, runs one valid/ready bus transaction with byte enables,
// returns sign/zero-extended load data and stalls the core until the
// access completes. Misaligned requests are rejected without bus activity
// and accesses that sit in ADDR+RDATA for TIMEOUT cycles are abandoned.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), async active-low reset
//   i_memReq/Write      request and direction (1 = store), held while stalled
//   i_funct3            [1:0] size (byte/half/word/illegal), [2] zero-extend
//   i_addr, i_wdata     byte address and store data
//   o_stall             core holds its instruction
//   o_rdata/Valid       extended load data, one-cycle valid pulse
//   o_misaligned        one-cycle pulse, request rejected
//   o_busErr            one-cycle pulse, request timed out
//   o_bus*, i_bus*      bus request channel and read-data return
module data_mem_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdataValid,
    output logic        o_misaligned,
    output logic        o_busErr,
    output logic        o_busValid,
    input  logic        i_busReady,
    output logic        o_busWrite,
    output logic [31:0] o_busAddr,
    output logic [31:0] o_busWdata,
    output logic [3:0]  o_busBe,
    input  logic        i_busRvalid,
    input  logic [31:0] i_busRdata
);

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, DONE} state_t;

    localparam logic [8:0] TMO = TIMEOUT[8:0];

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;

    logic        mis;
    logic        accept;
    logic [8:0]  cnt_inc;
    logic        tmo;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] sh;
    logic [31:0] ext;

    assign mis = (i_funct3[1:0] == 2'b11) ||
                 (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                 (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);

    assign accept       = (state == IDLE) && i_memReq && !mis;
    assign o_misaligned = (state == IDLE) && i_memReq && mis;
    assign o_stall      = accept || (state == ADDR) || (state == RDATA);

    // Count includes the current cycle, so the TIMEOUT-th waiting cycle
    // without completion is the one that gives up.
    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign tmo     = cnt_inc >= TMO;

    // Lane-replicated store data and enables, computed from the request
    // and captured once at acceptance.
    always_comb begin
        be_n = 4'b1111;
        wd_n = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << i_addr[1:0];
                wd_n = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_n = i_addr[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!i_memWrite)
            be_n = 4'b0000;
    end

    // Alignment guarantees the low address bits select the lane directly
    // for both byte and half accesses.
    always_comb begin
        sh = i_busRdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{~uns_q & sh[7]}}, sh[7:0]};
            2'b01:   ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
            default: ext = i_busRdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            uns_q        <= 1'b0;
            o_busValid   <= 1'b0;
            o_busWrite   <= 1'b0;
            o_busAddr    <= 32'd0;
            o_busWdata   <= 32'd0;
            o_busBe      <= 4'b0000;
            o_rdata      <= 32'd0;
            o_rdataValid <= 1'b0;
            o_busErr     <= 1'b0;
        end else begin
            o_rdataValid <= 1'b0;
            o_busErr     <= 1'b0;
            if (state == ADDR || state == RDATA)
                cnt <= tmo ? TMO[7:0] : cnt_inc[7:0];
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q     <= i_funct3[1:0];
                        lane_q     <= i_addr[1:0];
                        uns_q      <= i_funct3[2];
                        o_busWrite <= i_memWrite;
                        o_busAddr  <= {i_addr[31:2], 2'b00};
                        o_busWdata <= wd_n;
                        o_busBe    <= be_n;
                        o_busValid <= 1'b1;
                        cnt        <= 8'd0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_busReady) begin
                        o_busValid <= 1'b0;
                        state      <= o_busWrite ? DONE : RDATA;
                    end else if (tmo) begin
                        o_busValid <= 1'b0;
                        o_busErr   <= 1'b1;
                        state      <= DONE;
                    end
                end
                RDATA: begin
                    if (i_busRvalid) begin
                        o_rdata      <= ext;
                        o_rdataValid <= 1'b1;
                        state        <= DONE;
                    end else if (tmo) begin
                        o_busErr <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;

    localparam int TMO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_memReq;
    logic        i_memWrite;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdataValid;
    logic        o_misaligned;
    logic        o_busErr;
    logic        o_busValid;
    logic        i_busReady;
    logic        o_busWrite;
    logic [31:0] o_busAddr;
    logic [31:0] o_busWdata;
    logic [3:0]  o_busBe;
    logic        i_busRvalid;
    logic [31:0] i_busRdata;

    int checks = 0;
    int errors = 0;

    data_mem_controller #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_memReq(i_memReq), .i_memWrite(i_memWrite), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdataValid(o_rdataValid),
        .o_misaligned(o_misaligned), .o_busErr(o_busErr),
        .o_busValid(o_busValid), .i_busReady(i_busReady), .o_busWrite(o_busWrite),
        .o_busAddr(o_busAddr), .o_busWdata(o_busWdata), .o_busBe(o_busBe),
        .i_busRvalid(i_busRvalid), .i_busRdata(i_busRdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_stall"}, o_stall, 1'b0);
        chk1({tag, "_valid"}, o_busValid, 1'b0);
        chk1({tag, "_write"}, o_busWrite, 1'b0);
        chk1({tag, "_rvalid"}, o_rdataValid, 1'b0);
        chk1({tag, "_err"}, o_busErr, 1'b0);
        chk32({tag, "_addr"}, o_busAddr, 32'd0);
        chk32({tag, "_wdata"}, o_busWdata, 32'd0);
        chk32({tag, "_rdata"}, o_rdata, 32'd0);
        chk32({tag, "_be"}, {28'd0, o_busBe}, 32'd0);
    endtask

    // One core request from presentation to retirement. The bus side answers
    // ready after rdy_dly extra cycles and rvalid after rv_dly extra cycles.
    // Expected values come from the access rules, not from the DUT.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input int rv_dly,
                          output int stalls, output logic to);
        logic [1:0]  sz;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] ext;
        int          n;
        sz  = f3[1:0];
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        be  = 4'b0000;
        bwd = wd;
        if (sz == 2'b00) begin
            bwd = {4{wd[7:0]}};
            if (wr) be = 4'b0001 << a[1:0];
        end else if (sz == 2'b01) begin
            bwd = {2{wd[15:0]}};
            if (wr) be = 4'b0011 << (2 * a[1]);
        end else if (wr) begin
            be = 4'b1111;
        end
        if (sz == 2'b00) begin
            ext = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
            if (!f3[2] && ext[7]) ext = ext | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            ext = (rd >> (16 * a[1])) & 32'h0000_FFFF;
            if (!f3[2] && ext[15]) ext = ext | 32'hFFFF_0000;
        end else begin
            ext = rd;
        end

        stalls = 0;
        to     = 1'b0;
        n      = 0;
        @(posedge i_clk); #1;
        i_memReq = 1'b1; i_memWrite = wr; i_funct3 = f3; i_addr = a; i_wdata = wd;
        i_busReady = 1'b0; i_busRvalid = 1'b0;
        @(negedge i_clk);
        chk1("misaligned", o_misaligned, mis);
        chk1("busvalid_idle", o_busValid, 1'b0);
        if (mis) begin
            chk1("stall_mis", o_stall, 1'b0);
            @(posedge i_clk); #1 i_memReq = 1'b0;
            @(negedge i_clk);
            chk1("busvalid_after_mis", o_busValid, 1'b0);
            chk1("stall_after_mis", o_stall, 1'b0);
            chk1("mis_pulse_end", o_misaligned, 1'b0);
            return;
        end
        chk1("stall_accept", o_stall, 1'b1);
        if (o_stall) stalls++;

        // address phase; stray rvalid here must be ignored
        for (int k = 0; k < TMO; k++) begin
            @(posedge i_clk); #1;
            i_busReady  = (k == rdy_dly);
            i_busRvalid = 1'($urandom_range(0, 1));
            i_busRdata  = $urandom;
            @(negedge i_clk);
            chk1("addr_valid", o_busValid, 1'b1);
            chk1("addr_stall", o_stall, 1'b1);
            chk1("addr_write", o_busWrite, wr);
            chk32("addr_addr", o_busAddr, {a[31:2], 2'b00});
            chk32("addr_be", {28'd0, o_busBe}, {28'd0, be});
            if (wr) chk32("addr_wdata", o_busWdata, bwd);
            if (o_stall) stalls++;
            n++;
            if (k == rdy_dly) break;
            if (n == TMO) begin to = 1'b1; break; end
        end

        if (!to && !wr) begin
            for (int k = 0; k < TMO; k++) begin
                @(posedge i_clk); #1;
                i_busReady  = 1'b0;
                i_busRvalid = (k == rv_dly);
                i_busRdata  = (k == rv_dly) ? rd : $urandom;
                @(negedge i_clk);
                chk1("rdata_stall", o_stall, 1'b1);
                chk1("rdata_valid", o_busValid, 1'b0);
                if (o_stall) stalls++;
                n++;
                if (k == rv_dly) break;
                if (n == TMO) begin to = 1'b1; break; end
            end
        end

        @(posedge i_clk); #1;
        i_busReady = 1'b0; i_busRvalid = 1'b0;
        @(negedge i_clk);
        chk1("done_stall", o_stall, 1'b0);
        chk1("done_busvalid", o_busValid, 1'b0);
        chk1("done_buserr", o_busErr, to);
        chk1("done_rvalid", o_rdataValid, !wr && !to);
        if (!wr && !to) chk32("done_rdata", o_rdata, ext);

        @(posedge i_clk); #1 i_memReq = 1'b0;
        @(negedge i_clk);
        chk1("after_rvalid", o_rdataValid, 1'b0);
        chk1("after_buserr", o_busErr, 1'b0);
        chk1("after_stall", o_stall, 1'b0);
        chk1("after_busvalid", o_busValid, 1'b0);
    endtask

    initial begin
        int          st;
        logic        to;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          rdy;
        int          rv;

        i_rst_n = 1'b0; i_memReq = 1'b0; i_memWrite = 1'b0; i_funct3 = 3'b000;
        i_addr = 32'd0; i_wdata = 32'd0; i_busReady = 1'b0; i_busRvalid = 1'b0;
        i_busRdata = 32'd0;
        #1;
        chk_quiet("reset");
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // store byte, zero wait
        access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0, st, to);
        chk32("sb_stalls", st, 2);

        // load half signed / unsigned
        access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_1234, 0, 0, st, to);
        chk32("lh_stalls", st, 3);
        access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8001_1234, 0, 0, st, to);
        chk32("lhu_stalls", st, 3);

        // misaligned word and half
        access(1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0, 0, st, to);
        access(1'b0, 3'b001, 32'h0000_3001, 32'd0, 32'd0, 0, 0, st, to);

        // wait states: lbu with ready +3, rvalid +2
        access(1'b0, 3'b100, 32'h0000_4001, 32'd0, 32'h1122_3344, 3, 2, st, to);
        chk32("ws_stalls", st, 8);
        chk1("ws_no_timeout", to, 1'b0);

        // timeout: ready never arrives
        access(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'd0, 1000, 0, st, to);
        chk1("timeout_flag", to, 1'b1);

        // store timeout
        access(1'b1, 3'b010, 32'h0000_5004, 32'hDEAD_BEEF, 32'd0, 1000, 0, st, to);
        chk1("timeout_store", to, 1'b1);

        // reset during RDATA
        @(posedge i_clk); #1;
        i_memReq = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_6000;
        @(posedge i_clk); #1 i_busReady = 1'b1;
        @(posedge i_clk); #1;
        i_busReady = 1'b0; i_memReq = 1'b0; i_rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_busRvalid = 1'b1; i_busRdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        chk1("stray_rvalid_out", o_rdataValid, 1'b0);
        chk1("stray_stall", o_stall, 1'b0);
        @(posedge i_clk); #1 i_busRvalid = 1'b0;
        @(negedge i_clk);
        chk1("stray_rvalid_late", o_rdataValid, 1'b0);
        chk32("stray_rdata", o_rdata, 32'd0);
        access(1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h1357_9BDF, 0, 1, st, to);
        chk32("fresh_stalls", st, 4);

        // randomized traffic; delays up to 3+3 reach the timeout boundary
        for (int i = 0; i < 60; i++) begin
            wr  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            rdy = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
            rv  = int'($urandom_range(0, 3));
            access(wr, f3, a, $urandom, $urandom, rdy, rv, st, to);
        end

        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
